// File: rtl/bigmem_fifo_ctrl.sv
// rtl/bigmem_fifo_ctrl.sv - ring-buffer FIFO initiator for the single-port sync-read sample memory
// Optional occupancy output `level` is built only when BIGMEM_FIFO_LEVEL_EN is defined.
module bigmem_fifo_ctrl #(
   parameter int                    ADDR_WIDTH = 23,
   parameter int                    DATA_WIDTH = 16,
   parameter int                    SIZE_LOG2  = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
`ifdef BIGMEM_FIFO_LEVEL_EN
   output logic [SIZE_LOG2:0]    level,
`endif
   input  logic [DATA_WIDTH-1:0] mem_dout
);

   localparam logic [SIZE_LOG2:0] RING_WORDS = {1'b1, {SIZE_LOG2{1'b0}}};

   logic [SIZE_LOG2:0]    wr_ptr_q, wr_ptr_d;
   logic [SIZE_LOG2:0]    rd_ptr_q, rd_ptr_d;
   logic                  rd_pend_q, rd_pend_d;
   logic                  prio_q, prio_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

   logic [SIZE_LOG2:0]    fill;
   logic                  empty, full, rd_ok, in_ready_c, wr_issue, rd_issue;
   logic [SIZE_LOG2-1:0]  slot;

   always_comb begin
      fill       = wr_ptr_q - rd_ptr_q;
      empty      = (fill == '0);
      full       = (fill == RING_WORDS);
      rd_ok      = !empty && !rd_pend_q && (!out_valid_q || out_ready);
      // Write readiness never looks at in_valid, so the upstream handshake stays loop-free.
      in_ready_c = !full && (!rd_ok || !prio_q);
      wr_issue   = in_valid && in_ready_c;
      rd_issue   = rd_ok && !wr_issue;

      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      prio_d      = prio_q;
      rd_pend_d   = rd_issue;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      if (wr_issue) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         prio_d   = 1'b1;
      end else if (rd_issue) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         prio_d   = 1'b0;
      end

      // A returning word refills the output register even while it is being popped.
      if (rd_pend_q) begin
         out_valid_d = 1'b1;
         out_data_d  = mem_dout;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      slot     = wr_issue ? wr_ptr_q[SIZE_LOG2-1:0] : rd_ptr_q[SIZE_LOG2-1:0];
      mem_we   = wr_issue;
      mem_addr = BASE_ADDR | ADDR_WIDTH'(slot);
      mem_din  = in_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         rd_pend_q   <= 1'b0;
         prio_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         rd_pend_q   <= rd_pend_d;
         prio_q      <= prio_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign in_ready  = in_ready_c;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

`ifdef BIGMEM_FIFO_LEVEL_EN
   logic [SIZE_LOG2:0] level_q, level_d;

   // Computed from next-state values so level matches the registers it describes.
   always_comb begin
      level_d = (wr_ptr_d - rd_ptr_d) + {{SIZE_LOG2{1'b0}}, rd_pend_d}
              + {{SIZE_LOG2{1'b0}}, out_valid_d};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) level_q <= '0;
      else          level_q <= level_d;
   end

   assign level = level_q;
`endif

endmodule

// File: tb/tb_bigmem_fifo_ctrl.sv
// tb/tb_bigmem_fifo_ctrl.sv - self-checking bench for bigmem_fifo_ctrl with a 16-word ring
module tb_bigmem_fifo_ctrl;
   localparam int          AW   = 23;
   localparam int          DW   = 16;
   localparam int          SL   = 4;
   localparam int          RING = 1 << SL;
   localparam logic [AW-1:0] BASE = 23'h000120;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, mem_we;
   logic [DW-1:0] in_data = '0, out_data, mem_din, mem_dout = '0;
   logic [AW-1:0] mem_addr;
   logic [SL:0]   level;

   int vectors = 0, miscompares = 0;
   int acc_cnt = 0;
   logic [DW-1:0] popq[$];

   // Bench-level model: words in the ring, one word in flight, the output slot.
   logic [DW-1:0] m_ring[$];
   logic          m_pend, m_outv, m_prio;
   logic [DW-1:0] m_pend_w, m_outw;
   int            m_wcnt, m_rcnt;

   always #5 clk = ~clk;

   bigmem_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SIZE_LOG2(SL), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
`ifdef BIGMEM_FIFO_LEVEL_EN
      .level(level),
`endif
      .mem_dout(mem_dout)
   );
`ifndef BIGMEM_FIFO_LEVEL_EN
   assign level = '0;
`endif

   logic [DW-1:0] ram [0:RING-1];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr[SL-1:0]] <= mem_din;
      else        mem_dout <= ram[mem_addr[SL-1:0]];
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic rd_ok, rdy, wr, rd;
      logic [AW-1:0] addr_e;
      if (!reset_n) begin
         m_ring.delete();
         m_pend = 0; m_outv = 0; m_prio = 0; m_outw = '0; m_pend_w = '0;
         m_wcnt = 0; m_rcnt = 0;
      end
      rd_ok  = (m_ring.size() != 0) && !m_pend && (!m_outv || out_ready);
      rdy    = (m_ring.size() < RING) && (!rd_ok || !m_prio);
      wr     = in_valid && rdy;
      rd     = rd_ok && !wr;
      addr_e = BASE + AW'((wr ? m_wcnt : m_rcnt) % RING);
      chk("in_ready", in_ready, rdy);
      chk("out_valid", out_valid, m_outv);
      chk("out_data", out_data, m_outw);
      chk("mem_we", mem_we, wr);
      chk("mem_addr", mem_addr, addr_e);
      if (wr) chk("mem_din", mem_din, in_data);
`ifdef BIGMEM_FIFO_LEVEL_EN
      chk("level", level, m_ring.size() + int'(m_pend) + int'(m_outv));
`endif
      if (reset_n) begin
         if (in_valid && in_ready) acc_cnt++;
         if (out_valid && out_ready) popq.push_back(out_data);
         if (m_pend) begin
            m_outv = 1; m_outw = m_pend_w; m_pend = 0;
         end else if (out_ready) m_outv = 0;
         if (wr) begin
            m_ring.push_back(in_data); m_wcnt++; m_prio = 1;
         end
         if (rd) begin
            m_pend_w = m_ring.pop_front(); m_pend = 1; m_rcnt++; m_prio = 0;
         end
      end
   end

   task automatic cycle(input int n = 1);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      cycle(3);
      reset_n = 1'b1;
      cycle(2);

      // 1: single word, latency and address
      in_valid = 1; in_data = 16'h1234; out_ready = 1;
      @(negedge clk); #1;
      chk("t1_we", mem_we, 1); chk("t1_addr", mem_addr, BASE);
      @(posedge clk); #1; in_valid = 0;
`ifdef BIGMEM_FIFO_LEVEL_EN
      chk("t1_level1", level, 1);
`endif
      @(negedge clk); #1;
      chk("t1_rd_we", mem_we, 0); chk("t1_rd_addr", mem_addr, BASE);
      cycle(1); chk("t1_ov_early", out_valid, 0);
      cycle(1); chk("t1_ov", out_valid, 1); chk("t1_data", out_data, 16'h1234);
      cycle(1); chk("t1_ov_drain", out_valid, 0);
`ifdef BIGMEM_FIFO_LEVEL_EN
      chk("t1_level0", level, 0);
`endif

      // 2: 16 words held, then drained in order
      out_ready = 0; acc_cnt = 0; k = 1;
      for (int i = 0; i < 60 && acc_cnt < 16; i++) begin
         in_valid = 1; in_data = DW'(acc_cnt + 1);
         cycle(1);
      end
      in_valid = 0;
      chk("t2_accepted", acc_cnt, 16);
      popq.delete(); out_ready = 1; cycle(40);
      chk("t2_popcount", popq.size(), 16);
      foreach (popq[i]) chk("t2_order", popq[i], i + 1);

      // 3: full at 17 words, one pop admits one write
      out_ready = 0; in_valid = 1; acc_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         in_data = 16'(16'h0A00 + i); cycle(1);
      end
      chk("t3_accepted", acc_cnt, 17); chk("t3_in_ready", in_ready, 0);
`ifdef BIGMEM_FIFO_LEVEL_EN
      chk("t3_level", level, 17);
`endif
      out_ready = 1; cycle(1); out_ready = 0; acc_cnt = 0;
      cycle(20);
      chk("t3_refill", acc_cnt, 1);
      in_valid = 0; out_ready = 1; cycle(50);

      // 4: random traffic across many wraps
      for (int i = 0; i < 300; i++) begin
         in_valid = 1'($urandom % 2); out_ready = ($urandom % 3) != 0;
         in_data = DW'($urandom); cycle(1);
      end
      in_valid = 0; out_ready = 1; cycle(50);
      chk("t4_empty", out_valid, 0);

      // 5: continuous contention
      for (int i = 0; i < 40; i++) begin
         in_valid = 1; out_ready = 1; in_data = DW'($urandom); cycle(1);
      end
      in_valid = 0; cycle(50);

      // 6: reset with a read in flight
      out_ready = 0; acc_cnt = 0;
      for (int i = 0; i < 20 && acc_cnt < 5; i++) begin
         in_valid = 1; in_data = DW'(16'h0600 + i); cycle(1);
      end
      in_valid = 0; out_ready = 1;
      for (int i = 0; i < 10 && !m_pend; i++) cycle(1);
      chk("t6_pend_reached", m_pend, 1);
      reset_n = 0; #1;
      chk("t6_ov_async", out_valid, 0);
      cycle(1);
      chk("t6_in_ready", in_ready, 1);
`ifdef BIGMEM_FIFO_LEVEL_EN
      chk("t6_level", level, 0);
`endif
      reset_n = 1; cycle(1);
      in_valid = 1; in_data = 16'hBEEF; cycle(1); in_valid = 0;
      for (int i = 0; i < 8 && !out_valid; i++) cycle(1);
      chk("t6_ov", out_valid, 1); chk("t6_first", out_data, 16'hBEEF);
      cycle(5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
